// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
//   Multi-cycle data memory for a RISC-V style core. A load or store is taken
//   while the unit is idle, held for LATENCY wait cycles, then completed with a
//   one-cycle valid pulse. Misaligned or unsupported accesses complete on the
//   cycle after acceptance with err=1 and never touch the storage array.
//
// Parameters
//   DM_ADDRESS : byte-address width; storage is 2^(DM_ADDRESS-2) 32-bit words
//   LATENCY    : wait cycles per legal access, 1..15
//   DATA_W     : data width, only 32 is supported
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous active-high reset (storage array is not cleared)
//   req       : access request, looked at only while ready=1
//   MemRead   : load qualifier
//   MemWrite  : store qualifier, wins over MemRead when both are set
//   a         : byte address
//   wd        : store data, low bits used for SB/SH
//   Funct3    : access size/sign (instruction bits 14:12)
//   rd        : registered load result, held until the next load completes
//   ready     : unit idle, a request can be accepted this cycle
//   valid     : one-cycle completion pulse for loads and stores
//   err       : misaligned/unsupported flag, only meaningful with valid
//   state_dbg : current FSM state (0 idle, 1 wait, 2 done)
//
// Handshake: a request is taken on the rising edge where ready=1, req=1 and at
// least one of MemRead/MemWrite is set; ready then stays low until the edge
// after the valid pulse, so exactly one valid answers each accepted request.
// -----------------------------------------------------------------------------
module data_mem_unit #(
   parameter int DM_ADDRESS = 9,
   parameter int LATENCY    = 2,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] a,
   input  logic [DATA_W-1:0]     wd,
   input  logic [2:0]            Funct3,
   output logic [DATA_W-1:0]     rd,
   output logic                  ready,
   output logic                  valid,
   output logic                  err,
   output logic [1:0]            state_dbg
);

   localparam int WORDS = 2 ** (DM_ADDRESS - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_n;
   logic [3:0] cnt, cnt_n;

   // Request captured at acceptance
   logic                  op_wr;
   logic                  bad_q;
   logic [DM_ADDRESS-1:0] a_q;
   logic [DATA_W-1:0]     wd_q;
   logic [2:0]            f3_q;
   logic [DATA_W-1:0]     rd_q;

   logic [DATA_W-1:0] mem [WORDS];

   logic              accept;
   logic              unsupported;
   logic              misaligned;
   logic              bad;
   logic              finish;
   logic [3:0]        be;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] word;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [DATA_W-1:0] load_val;

   // Acceptance and legality of the request on the inputs
   always_comb begin
      accept      = (state == IDLE) && req && (MemRead || MemWrite);
      unsupported = 1'b0;
      misaligned  = 1'b0;
      if (MemWrite) begin
         unsupported = (Funct3 > 3'b010);
      end else begin
         unsupported = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
      end
      // Funct3[1:0] encodes size for every legal code: 0 byte, 1 half, 2 word
      if (Funct3[1:0] == 2'b01) misaligned = a[0];
      if (Funct3[1:0] == 2'b10) misaligned = (a[1:0] != 2'b00);
      bad = unsupported || misaligned;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bad) begin
                  state_n = DONE;
                  cnt_n   = 4'd0;
               end else begin
                  state_n = WAIT;
                  cnt_n   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_n = DONE;
            else             cnt_n   = cnt - 4'd1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // The WAIT->DONE edge is where stores land and loads are captured
   assign finish = (state == WAIT) && (cnt == 4'd0);

   // Store lane enables and lane-replicated store data
   always_comb begin
      be    = 4'b0000;
      wdata = wd_q;
      case (f3_q[1:0])
         2'b00: begin
            be          = 4'b0001 << a_q[1:0];
            wdata       = {4{wd_q[7:0]}};
         end
         2'b01: begin
            be          = a_q[1] ? 4'b1100 : 4'b0011;
            wdata       = {2{wd_q[15:0]}};
         end
         default: be    = 4'b1111;
      endcase
   end

   // Load extraction with sign/zero extension
   always_comb begin
      word     = mem[a_q[DM_ADDRESS-1:2]];
      byte_v   = word[{a_q[1:0], 3'b000} +: 8];
      half_v   = word[{a_q[1], 4'b0000} +: 16];
      load_val = word;
      case (f3_q)
         3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
         3'b001:  load_val = {{16{half_v[15]}}, half_v};
         3'b100:  load_val = {24'd0, byte_v};
         3'b101:  load_val = {16'd0, half_v};
         default: load_val = word;
      endcase
   end

   // State, counter and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         rd_q  <= '0;
         bad_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            bad_q <= bad;
            // A failed load reports zero; a failed store leaves rd alone
            if (bad && !MemWrite) rd_q <= '0;
         end
         if (finish && !op_wr) rd_q <= load_val;
      end
   end

   // Request capture; no reset needed since only read after an accept
   always_ff @(posedge clk) begin
      if (accept) begin
         op_wr <= MemWrite;
         a_q   <= a;
         wd_q  <= wd;
         f3_q  <= Funct3;
      end
   end

   // Storage array: not cleared by reset; a reset on the completion edge
   // cancels the pending store
   always_ff @(posedge clk) begin
      if (!reset && finish && op_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[a_q[DM_ADDRESS-1:2]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign ready     = (state == IDLE);
   assign valid     = (state == DONE);
   assign err       = valid && bad_q;
   assign rd        = rd_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_data_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_data_mem_unit
//   Bench for data_mem_unit. The reference keeps storage as a plain byte array
//   and computes each access result from the size/sign/alignment rules; a
//   compare process checks ready/valid/rd/err every cycle against queued
//   expectations.
// -----------------------------------------------------------------------------
module tb_data_mem_unit;

   localparam int AW  = 9;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req = 1'b0;
   logic          MemRead = 1'b0;
   logic          MemWrite = 1'b0;
   logic [AW-1:0] a = '0;
   logic [31:0]   wd = '0;
   logic [2:0]    Funct3 = '0;
   logic [31:0]   rd;
   logic          ready;
   logic          valid;
   logic          err;
   logic [1:0]    state_dbg;

   data_mem_unit #(.DM_ADDRESS(AW), .LATENCY(LAT), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .req(req), .MemRead(MemRead), .MemWrite(MemWrite),
      .a(a), .wd(wd), .Funct3(Funct3), .rd(rd), .ready(ready), .valid(valid),
      .err(err), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [31:0] held_rd = '0;
   logic [31:0] model_rd = '0;
   logic [7:0]  mb [2**AW];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, got, exp);
      end
   endtask

   // Reference: byte-addressed little-endian memory
   function automatic void model_exec(input bit wr, input logic [2:0] f3, input logic [AW-1:0] addr,
                                      input logic [31:0] data, input bit commit,
                                      output bit e, output logic [31:0] r, output bit upd);
      int nb;
      bit legal;
      logic [31:0] v;
      nb = 1 << f3[1:0];
      if (wr) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
      else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      e   = !legal || ((int'(addr) % nb) != 0);
      r   = 32'd0;
      upd = 1'b0;
      if (e) begin
         upd = !wr;
      end else if (wr) begin
         if (commit)
            for (int b = 0; b < nb; b++) mb[int'(addr) + b] = data[8*b +: 8];
      end else begin
         v = 32'd0;
         for (int b = 0; b < nb; b++) v[8*b +: 8] = mb[int'(addr) + b];
         if (!f3[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
         if (!f3[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
         r   = v;
         upd = 1'b1;
      end
   endfunction

   // ---------------- compare process ----------------
   always @(posedge clk) begin
      logic rst_s;
      exp_t e;
      rst_s = reset;
      cyc++;
      #1;
      if (rst_s) begin
         exp_q.delete();
         held_rd = '0;
         chk("rst_valid", valid, 0);
         chk("rst_ready", ready, 1);
         chk("rst_err", err, 0);
         chk("rst_rd", rd, 0);
      end else begin
         chk("ready", ready, (exp_q.size() == 0));
         if (valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("latency_cycle", cyc, e.due);
               chk("rd", rd, e.rd);
               chk("err", err, e.err);
               held_rd = e.rd;
            end
         end else begin
            chk("err_idle", err, 0);
            chk("rd_hold", rd, held_rd);
            if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
               chk("valid_missing", valid, 1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present one request when ready and queue its expected outcome.
   task automatic present(input bit wr, input bit rdq, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [2:0] f3, input bit commit);
      int n;
      exp_t e;
      bit er;
      bit upd;
      logic [31:0] r;
      @(negedge clk);
      n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         chk("ready_timeout", ready, 1);
         return;
      end
      req = 1'b1; MemWrite = wr; MemRead = rdq; a = addr; wd = data; Funct3 = f3;
      if (wr || rdq) begin
         model_exec(wr, f3, addr, data, commit, er, r, upd);
         if (upd) model_rd = r;
         e.rd  = model_rd;
         e.err = er;
         e.due = cyc + (er ? 1 : LAT + 1);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // While the access is in flight keep junk requests on the inputs.
   task automatic finish_busy();
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
         req = 1'b1; MemRead = 1'($urandom); MemWrite = 1'($urandom);
         a = AW'($urandom); wd = $urandom; Funct3 = 3'($urandom);
      end
      req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic issue(input bit wr, input bit rdq, input logic [AW-1:0] addr,
                        input logic [31:0] data, input logic [2:0] f3);
      present(wr, rdq, addr, data, f3, 1'b1);
      if (wr || rdq) finish_busy();
      else begin
         req = 1'b0;
      end
   endtask

   // Store, then reset one cycle into WAIT with a load request held on the pins.
   task automatic reset_abort(input logic [AW-1:0] addr, input logic [31:0] data);
      present(1'b1, 1'b0, addr, data, 3'b010, 1'b0);
      @(negedge clk);
      reset = 1'b1; req = 1'b1; MemWrite = 1'b0; MemRead = 1'b1; Funct3 = 3'b010;
      model_rd = '0;
      @(negedge clk);
      reset = 1'b0; req = 1'b0; MemRead = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit wr, rdq;
      int op;
      for (int i = 0; i < 2**AW; i++) mb[i] = 8'h00;

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Storage is not reset, so start from a known all-zero image
      for (int w = 0; w < 2**(AW-2); w++) issue(1'b1, 1'b0, AW'(w*4), 32'd0, 3'b010);

      // Directed accesses with hand-derived results
      issue(1'b1, 1'b0, 9'h010, 32'hDEADBEEF, 3'b010);
      issue(1'b0, 1'b1, 9'h010, 32'd0, 3'b010);
      chk("lit_lw_010", model_rd, 32'hDEADBEEF);
      issue(1'b1, 1'b0, 9'h011, 32'h0000007F, 3'b000);
      issue(1'b0, 1'b1, 9'h011, 32'd0, 3'b000);
      chk("lit_lb_011", model_rd, 32'h0000007F);
      issue(1'b0, 1'b1, 9'h013, 32'd0, 3'b100);
      chk("lit_lbu_013", model_rd, 32'h000000DE);
      issue(1'b0, 1'b1, 9'h013, 32'd0, 3'b000);
      chk("lit_lb_013", model_rd, 32'hFFFFFFDE);
      issue(1'b0, 1'b1, 9'h012, 32'd0, 3'b001);
      chk("lit_lh_012", model_rd, 32'hFFFFDEAD);
      issue(1'b1, 1'b0, 9'h016, 32'h00008001, 3'b001);
      issue(1'b0, 1'b1, 9'h016, 32'd0, 3'b101);
      chk("lit_lhu_016", model_rd, 32'h00008001);
      issue(1'b0, 1'b1, 9'h014, 32'd0, 3'b010);
      chk("lit_lw_014", model_rd, 32'h80010000);

      // Error accesses
      issue(1'b0, 1'b1, 9'h012, 32'd0, 3'b010);
      chk("lit_lw_mis_rd", model_rd, 32'h00000000);
      issue(1'b1, 1'b0, 9'h015, 32'hFFFFFFFF, 3'b001);
      issue(1'b0, 1'b1, 9'h010, 32'd0, 3'b011);
      issue(1'b1, 1'b1, 9'h010, 32'd0, 3'b100);   // both set: store wins, SB code 100 unsupported
      issue(1'b0, 1'b1, 9'h014, 32'd0, 3'b010);
      chk("lit_lw_014_after_err", model_rd, 32'h80010000);
      issue(1'b0, 1'b0, 9'h010, 32'h11111111, 3'b010);   // neither qualifier: ignored

      // Reset aborting a store in WAIT, with a request held during reset
      reset_abort(9'h020, 32'h12345678);
      issue(1'b0, 1'b1, 9'h020, 32'd0, 3'b010);
      chk("lit_lw_020_after_abort", model_rd, 32'h00000000);

      // Random traffic over a small window so loads hit earlier stores
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 19);
         if (op == 0) begin
            issue(1'b0, 1'b0, AW'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)));
         end else if (op == 1) begin
            reset_abort(AW'($urandom_range(0, 15) * 4), $urandom);
         end else begin
            wr  = 1'($urandom_range(0, 1));
            rdq = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            issue(wr, rdq, AW'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)));
         end
      end

      for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
